// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-stream load port of the instruction ROM loader.
// The master side is the CPU/loader; the slave side is the ROM block.
interface inst_rom_loader_if #(
  parameter int AW = 10
);
  logic          ce_i;
  logic [31:0]   addr_i;
  logic [31:0]   inst_o;
  logic          busy_o;
  logic          ld_start_i;
  logic          ld_valid_i;
  logic [7:0]    ld_byte_i;
  logic          ld_last_i;
  logic          ld_ready_o;
  logic          ld_done_o;
  logic          ld_err_o;
  logic [AW:0]   ld_count_o;

  modport master (
    output ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
    input  inst_o, busy_o, ld_ready_o, ld_done_o, ld_err_o, ld_count_o
  );

  modport slave (
    input  ce_i, addr_i, ld_start_i, ld_valid_i, ld_byte_i, ld_last_i,
    output inst_o, busy_o, ld_ready_o, ld_done_o, ld_err_o, ld_count_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with a combinational fetch port and a big-endian byte-stream
// loader that packs bytes into 32-bit words and writes them from address 0.
module inst_rom_loader #(
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  inst_rom_loader_if.slave   bus
);

  typedef enum logic {RUN, LOAD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [2**AW];
  logic [AW:0]   ptr;
  logic [1:0]    bidx;
  logic [31:0]   asm_word;
  logic          err;
  logic          done;
  logic          accept;
  logic          word_end;
  logic          wr_en;
  logic [4:0]    shamt;
  logic [31:0]   wdata;
  logic [1:0]    unused_addr;

  // Next state plus the word being assembled with the incoming byte merged in
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    word_end  = 1'b0;
    wr_en     = 1'b0;
    shamt     = {~bidx, 3'b000};
    wdata     = asm_word | ({24'h0, bus.ld_byte_i} << shamt);
    case (state)
      RUN: begin
        if (bus.ld_start_i) state_nxt = LOAD;
      end
      LOAD: begin
        accept   = bus.ld_valid_i;
        word_end = accept && ((bidx == 2'd3) || bus.ld_last_i);
        // ptr[AW] set means the array is full: further words are dropped
        wr_en    = word_end && !ptr[AW];
        if (accept && bus.ld_last_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      bidx     <= 2'd0;
      asm_word <= 32'h0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= accept && bus.ld_last_i;
      if ((state == RUN) && bus.ld_start_i) begin
        ptr      <= '0;
        bidx     <= 2'd0;
        asm_word <= 32'h0;
        err      <= 1'b0;
      end else if (accept) begin
        if (word_end) begin
          bidx     <= 2'd0;
          asm_word <= 32'h0;
          if (ptr[AW]) err <= 1'b1;
          else         ptr <= ptr + 1'b1;
        end else begin
          bidx     <= bidx + 2'd1;
          asm_word <= wdata;
        end
      end
    end
  end

  // Contents deliberately survive reset so a loaded program outlives it
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr[AW-1:0]] <= wdata;
  end

  assign unused_addr    = bus.addr_i[1:0];
  assign bus.inst_o     = ((state == RUN) && bus.ce_i && (bus.addr_i[31:AW+2] == '0))
                          ? mem[bus.addr_i[AW+1:2]] : 32'h0;
  assign bus.busy_o     = (state == LOAD);
  assign bus.ld_ready_o = (state == LOAD);
  assign bus.ld_done_o  = done;
  assign bus.ld_err_o   = err;
  // Words written equals the pointer, which itself stops at 2^AW
  assign bus.ld_count_o = ptr;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: a 1024-word instance for the main traffic and a
// 4-word instance for overflow, both against a queue-based packing model.
module tb_inst_rom_loader;
  localparam int AW  = 10;
  localparam int AW2 = 2;

  typedef logic [31:0] wq_t[$];
  typedef logic [7:0]  bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] m10 [16];
  bit          k10 [16];
  logic [31:0] m2  [4];

  always #5 clk = ~clk;

  inst_rom_loader_if #(.AW(AW))  a10 ();
  inst_rom_loader_if #(.AW(AW2)) a2 ();

  inst_rom_loader #(.AW(AW))  dut10 (.clk(clk), .rst(rst), .bus(a10.slave));
  inst_rom_loader #(.AW(AW2)) dut2  (.clk(clk), .rst(rst), .bus(a2.slave));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic wq_t pack(input bq_t b);
    wq_t w;
    w = {};
    for (int i = 0; i < b.size(); i++) begin
      if (i % 4 == 0) w.push_back(32'h0);
      w[i/4] = w[i/4] | (32'(b[i]) << (8 * (3 - (i % 4))));
    end
    return w;
  endfunction

  task automatic idle();
    a10.ce_i = 0; a10.addr_i = 0; a10.ld_start_i = 0; a10.ld_valid_i = 0;
    a10.ld_byte_i = 0; a10.ld_last_i = 0;
    a2.ce_i = 0; a2.addr_i = 0; a2.ld_start_i = 0; a2.ld_valid_i = 0;
    a2.ld_byte_i = 0; a2.ld_last_i = 0;
  endtask

  task automatic send10(input logic [7:0] v, input bit last);
    a10.ld_valid_i = 1; a10.ld_byte_i = v; a10.ld_last_i = last;
    @(posedge clk); #1;
    a10.ld_valid_i = 0; a10.ld_last_i = 0;
  endtask

  task automatic send2(input logic [7:0] v, input bit last);
    a2.ld_valid_i = 1; a2.ld_byte_i = v; a2.ld_last_i = last;
    @(posedge clk); #1;
    a2.ld_valid_i = 0; a2.ld_last_i = 0;
  endtask

  task automatic drive10(input bq_t b, input bit gaps);
    a10.ld_start_i = 1;
    @(posedge clk); #1;
    a10.ld_start_i = 0;
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send10(b[i], i == b.size() - 1);
    end
  endtask

  task automatic drive2(input bq_t b);
    a2.ld_start_i = 1;
    @(posedge clk); #1;
    a2.ld_start_i = 0;
    for (int i = 0; i < b.size(); i++) begin
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      send2(b[i], i == b.size() - 1);
    end
  endtask

  task automatic rd10(input logic [31:0] a, output logic [31:0] d);
    a10.ce_i = 1; a10.addr_i = a; #1; d = a10.inst_o;
  endtask

  task automatic rd2(input logic [31:0] a, output logic [31:0] d);
    a2.ce_i = 1; a2.addr_i = a; #1; d = a2.inst_o;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    repeat (2) @(posedge clk); #1;
    got = {a10.busy_o, a10.ld_ready_o, a10.ld_done_o, a10.ld_err_o, |a10.ld_count_o};
    total++; if (got !== 5'b0) begin bad++; $display("FAIL reset_ctrl10: got %b want 00000", got); end
    got = {a2.busy_o, a2.ld_ready_o, a2.ld_done_o, a2.ld_err_o, |a2.ld_count_o};
    total++; if (got !== 5'b0) begin bad++; $display("FAIL reset_ctrl2: got %b want 00000", got); end
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst_ce0: got %h want 0", a10.inst_o); end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bq_t b;
    logic [31:0] d;
    b = {8'h34, 8'h01, 8'h00, 8'h0A, 8'h20, 8'h02, 8'h00, 8'h0B};
    drive10(b, 1'b0);
    total++; if (a10.ld_done_o !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", a10.ld_done_o); end
    total++; if (a10.ld_count_o !== 11'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", a10.ld_count_o); end
    total++; if (a10.ld_err_o !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", a10.ld_err_o); end
    total++; if (a10.busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", a10.busy_o); end
    rd10(32'd4, d);
    total++; if (d !== 32'h2002000B) begin bad++; $display("FAIL basic_mem1: got %h want 2002000b", d); end
    @(posedge clk); #1;
    total++; if (a10.ld_done_o !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", a10.ld_done_o); end
    rd10(32'd0, d);
    total++; if (d !== 32'h3401000A) begin bad++; $display("FAIL basic_mem0: got %h want 3401000a", d); end
    m10[0] = 32'h3401000A; k10[0] = 1; m10[1] = 32'h2002000B; k10[1] = 1;
  endtask

  task automatic test_partial();
    bq_t b;
    logic [31:0] d;
    b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive10(b, 1'b1);
    total++; if (a10.ld_count_o !== 11'd2) begin bad++; $display("FAIL partial_count: got %0d want 2", a10.ld_count_o); end
    total++; if (a10.ld_err_o !== 1'b0) begin bad++; $display("FAIL partial_err: got %b want 0", a10.ld_err_o); end
    rd10(32'd7, d);
    total++; if (d !== 32'h55000000) begin bad++; $display("FAIL partial_mem1: got %h want 55000000", d); end
    rd10(32'd1, d);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL partial_mem0: got %h want 11223344", d); end
    m10[0] = 32'h11223344; m10[1] = 32'h55000000;
  endtask

  task automatic test_load_mode();
    logic [31:0] d;
    // Stray load bytes while running must not reach the array
    for (int i = 0; i < 4; i++) begin
      a10.ld_valid_i = 1; a10.ld_byte_i = 8'($urandom); a10.ld_last_i = (i == 3);
      #1;
      total++; if (a10.ld_ready_o !== 1'b0) begin bad++; $display("FAIL run_ready: got %b want 0", a10.ld_ready_o); end
      @(posedge clk); #1;
    end
    a10.ld_valid_i = 0; a10.ld_last_i = 0;
    total++; if (a10.busy_o !== 1'b0) begin bad++; $display("FAIL run_busy: got %b want 0", a10.busy_o); end
    for (int i = 0; i < 2; i++) begin
      rd10(32'(i * 4), d);
      total++; if (d !== m10[i]) begin bad++; $display("FAIL run_discard_mem%0d: got %h want %h", i, d, m10[i]); end
    end
    // A byte offered on the start cycle is dropped; ld_start inside LOAD is ignored
    a10.ld_start_i = 1; a10.ld_valid_i = 1; a10.ld_byte_i = 8'hFF; a10.ld_last_i = 1;
    @(posedge clk); #1;
    a10.ld_start_i = 0; a10.ld_valid_i = 0; a10.ld_last_i = 0;
    a10.ce_i = 1; a10.addr_i = 0; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL load_inst: got %h want 0", a10.inst_o); end
    total++; if ({a10.busy_o, a10.ld_ready_o} !== 2'b11) begin bad++; $display("FAIL load_busy_ready: got %b want 11", {a10.busy_o, a10.ld_ready_o}); end
    total++; if (a10.ld_count_o !== 11'd0) begin bad++; $display("FAIL load_count0: got %0d want 0", a10.ld_count_o); end
    @(posedge clk); #1;
    send10(8'hA1, 0); send10(8'hA2, 0); send10(8'hA3, 0); send10(8'hA4, 0);
    a10.ld_start_i = 1;
    @(posedge clk); #1;
    a10.ld_start_i = 0;
    send10(8'hB1, 0); send10(8'hB2, 1);
    total++; if (a10.ld_count_o !== 11'd2) begin bad++; $display("FAIL restart_count: got %0d want 2", a10.ld_count_o); end
    total++; if (a10.ld_done_o !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", a10.ld_done_o); end
    rd10(32'd0, d);
    total++; if (d !== 32'hA1A2A3A4) begin bad++; $display("FAIL restart_mem0: got %h want a1a2a3a4", d); end
    rd10(32'd4, d);
    total++; if (d !== 32'hB1B20000) begin bad++; $display("FAIL restart_mem1: got %h want b1b20000", d); end
    m10[0] = 32'hA1A2A3A4; m10[1] = 32'hB1B20000;
  endtask

  task automatic test_random();
    bq_t b;
    wq_t w;
    logic [31:0] d;
    for (int it = 0; it < 8; it++) begin
      b = {};
      repeat ($urandom_range(1, 32)) b.push_back(8'($urandom));
      w = pack(b);
      drive10(b, 1'b1);
      total++; if (a10.ld_done_o !== 1'b1) begin bad++; $display("FAIL rand%0d_done: got %b want 1", it, a10.ld_done_o); end
      total++; if (a10.ld_count_o !== 11'(w.size())) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, a10.ld_count_o, w.size()); end
      total++; if (a10.ld_err_o !== 1'b0) begin bad++; $display("FAIL rand%0d_err: got %b want 0", it, a10.ld_err_o); end
      for (int i = 0; i < w.size(); i++) begin m10[i] = w[i]; k10[i] = 1; end
      for (int i = 0; i < 16; i++) begin
        if (k10[i]) begin
          rd10(32'(i * 4 + $urandom_range(0, 3)), d);
          total++; if (d !== m10[i]) begin bad++; $display("FAIL rand%0d_mem%0d: got %h want %h", it, i, d, m10[i]); end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addr_range();
    a10.ce_i = 1; a10.addr_i = 32'h0001_0000; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL range_hi16: got %h want 0", a10.inst_o); end
    a10.addr_i = 32'h0000_1000; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL range_bit12: got %h want 0", a10.inst_o); end
    a10.ce_i = 0; a10.addr_i = 0; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL range_ce0: got %h want 0", a10.inst_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lens [3] = '{16, 20, 17};
    bq_t b;
    wq_t w;
    logic [31:0] d;
    int n;
    bit ovf;
    for (int t = 0; t < 3; t++) begin
      b = {};
      repeat (lens[t]) b.push_back(8'($urandom));
      w = pack(b);
      n = (w.size() > 4) ? 4 : w.size();
      ovf = (w.size() > 4);
      drive2(b);
      total++; if (a2.ld_done_o !== 1'b1) begin bad++; $display("FAIL ovf%0d_done: got %b want 1", t, a2.ld_done_o); end
      total++; if (a2.ld_count_o !== 3'(n)) begin bad++; $display("FAIL ovf%0d_count: got %0d want %0d", t, a2.ld_count_o, n); end
      total++; if (a2.ld_err_o !== ovf) begin bad++; $display("FAIL ovf%0d_err: got %b want %b", t, a2.ld_err_o, ovf); end
      for (int i = 0; i < n; i++) m2[i] = w[i];
      for (int i = 0; i < 4; i++) begin
        rd2(32'(i * 4), d);
        total++; if (d !== m2[i]) begin bad++; $display("FAIL ovf%0d_mem%0d: got %h want %h", t, i, d, m2[i]); end
      end
      @(posedge clk); #1;
      total++; if (a2.ld_err_o !== ovf) begin bad++; $display("FAIL ovf%0d_sticky: got %b want %b", t, a2.ld_err_o, ovf); end
    end
    rd2(32'd16, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovf_range: got %h want 0", d); end
    a2.ld_start_i = 1;
    @(posedge clk); #1;
    a2.ld_start_i = 0;
    total++; if ({a2.ld_err_o, a2.busy_o} !== 2'b01) begin bad++; $display("FAIL ovf_clear: got %b want 01", {a2.ld_err_o, a2.busy_o}); end
    total++; if (a2.ld_count_o !== 3'd0) begin bad++; $display("FAIL ovf_clear_count: got %0d want 0", a2.ld_count_o); end
    send2(8'hAB, 1);
    total++; if (a2.ld_count_o !== 3'd1) begin bad++; $display("FAIL ovf_reload_count: got %0d want 1", a2.ld_count_o); end
    rd2(32'd2, d);
    total++; if (d !== 32'hAB000000) begin bad++; $display("FAIL ovf_reload_mem0: got %h want ab000000", d); end
    m2[0] = 32'hAB000000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    bq_t b;
    logic [31:0] d;
    logic [31:0] old1;
    logic [4:0] got;
    old1 = m10[1];
    b = {};
    repeat (6) b.push_back(8'($urandom));
    a10.ld_start_i = 1;
    @(posedge clk); #1;
    a10.ld_start_i = 0;
    for (int i = 0; i < 6; i++) send10(b[i], 1'b0);
    rst = 0; #2;
    got = {a10.busy_o, a10.ld_ready_o, a10.ld_done_o, a10.ld_err_o, |a10.ld_count_o};
    total++; if (got !== 5'b0) begin bad++; $display("FAIL midrst_ctrl: got %b want 00000", got); end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    m10[0] = pack(b)[0];
    rd10(32'd0, d);
    total++; if (d !== m10[0]) begin bad++; $display("FAIL midrst_mem0: got %h want %h", d, m10[0]); end
    rd10(32'd4, d);
    total++; if (d !== old1) begin bad++; $display("FAIL midrst_mem1: got %h want %h", d, old1); end
    a10.ce_i = 0; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL midrst_ce0: got %h want 0", a10.inst_o); end
    a10.ce_i = 1; a10.addr_i = 32'h0001_0000; #1;
    total++; if (a10.inst_o !== 32'h0) begin bad++; $display("FAIL midrst_range: got %h want 0", a10.inst_o); end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) k10[i] = 0;
    test_reset();
    test_basic();
    test_partial();
    test_load_mode();
    test_random();
    test_addr_range();
    test_overflow();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 Parameter AW, default 10, word-address width; memory holds 2^AW 32-bit words.
REQ-002 clk  input  1  single clock for the whole block, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ce_i  input  1  fetch enable from CPU (CPU rom_ce_o).
REQ-005 addr_i  input  32  fetch byte address from CPU (CPU rom_addr_o).
REQ-006 inst_o  output  32  fetched instruction to CPU (CPU rom_data_i).
REQ-007 busy_o  output  1  high while a load is in progress; CPU fetch data not valid.
REQ-008 ld_start_i  input  1  single-cycle request to begin a program load.
REQ-009 ld_valid_i  input  1  load byte valid.
REQ-010 ld_byte_i  input  8  load byte.
REQ-011 ld_last_i  input  1  qualifies the final byte of the image; sampled with ld_valid_i.
REQ-012 ld_ready_o  output  1  block accepts a load byte this cycle.
REQ-013 ld_done_o  output  1  one-cycle pulse when a load completes.
REQ-014 ld_err_o  output  1  sticky overflow flag for the current/last load.
REQ-015 ld_count_o  output  AW+1  number of words written by the current/last load.

Function
REQ-016 The block SHALL implement two states, RUN and LOAD; reset state RUN.
REQ-017 In RUN, inst_o SHALL be combinational: mem[addr_i[AW+1:2]] when ce_i=1 and addr_i[31:AW+2]=0, else 32'h0.
REQ-018 In RUN, addr_i[1:0] SHALL be ignored; no alignment check.
REQ-019 In LOAD, inst_o SHALL be 32'h0 (NOP) regardless of ce_i/addr_i; busy_o=1.
REQ-020 RUN -> LOAD SHALL occur on the clock edge where ld_start_i=1; on that edge: word pointer=0, byte index=0, assembly register=0, ld_count_o=0, ld_err_o=0.
REQ-021 ld_start_i in LOAD SHALL be ignored.
REQ-022 ld_ready_o SHALL be 1 exactly in LOAD; a byte is accepted when ld_valid_i & ld_ready_o.
REQ-023 ld_valid_i in RUN (including the ld_start_i cycle) SHALL be discarded.
REQ-024 Accepted bytes SHALL be packed big-endian: byte index 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0.
REQ-025 On acceptance of byte index 3, the completed word SHALL be written to mem[word pointer] on that edge; pointer +1, ld_count_o +1, byte index -> 0.
REQ-026 On accepted byte with ld_last_i=1 at byte index 0-2, the partial word SHALL be written with unfilled low bytes = 8'h00, counted as one word.
REQ-027 Accepted byte with ld_last_i=1 SHALL return the FSM to RUN on that edge; ld_done_o=1 for the following cycle only.
REQ-028 Write latency: a written word SHALL be fetchable via inst_o in the first RUN cycle after ld_done_o rises.
REQ-029 Overflow: when pointer = 2^AW, a would-be word write SHALL be suppressed, ld_err_o set to 1, ld_count_o saturate at 2^AW; bytes still accepted until ld_last_i.
REQ-030 ld_err_o SHALL hold until the next RUN -> LOAD transition or reset.
REQ-031 Words not rewritten by a load SHALL retain prior contents.
REQ-032 The memory SHALL be a single-write-port, single-combinational-read-port array; no write in RUN.

Reset
REQ-033 On rst=0, asynchronously: state=RUN, busy_o=0, ld_ready_o=0, ld_done_o=0, ld_err_o=0, ld_count_o=0, pointer=0, byte index=0, assembly register=0.
REQ-034 Memory contents SHALL NOT be cleared by reset; a reset mid-LOAD abandons the partial word (not written) and keeps already-written words.
REQ-035 inst_o SHALL follow REQ-017 immediately after reset release (combinational from memory).

Verification
REQ-036 ld_start, bytes 34 01 00 0A, 20 02 00 0B(last) -> mem[0]=3401000A, mem[1]=2002000B, ld_count_o=2, ld_done_o one pulse; then ce_i=1, addr_i=4 -> inst_o=2002000B.
REQ-037 Load 5 bytes 11 22 33 44 55(last) -> mem[1]=55000000, ld_count_o=2, ld_err_o=0.
REQ-038 During LOAD, ce_i=1, addr_i=0 -> inst_o=0, busy_o=1; ld_valid_i=1 in RUN -> no memory change, ld_ready_o=0.
REQ-039 AW=2: load 5 full words -> words 0-3 written, ld_err_o=1, ld_count_o=4, mem unchanged by 5th word; next ld_start clears ld_err_o.
REQ-040 rst=0 after 6 bytes of a load -> state RUN, busy_o=0, mem[0] holds new word, mem[1] holds old contents; ce_i=0 -> inst_o=0; addr_i=32'h0001_0000 with AW=10 -> inst_o=0.
